reset_sequencer: RTL and testbench

//  Parametrised multi-channel reset generator; successor to the single-output delay/width reset block.

---
 rtl/reset_seq_pkg.sv | 26 ++
 rtl/reset_sync_2ff.sv | 23 ++
 rtl/reset_sequencer.sv | 125 ++++++++++++
 tb/tb_reset_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and elaboration helpers for the staggered reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_DELAY,
    ST_RELEASE,
    ST_RUN
  } seq_state_e;

  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int max3_f(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/reset_sync_2ff.sv
// Two-flop reset synchroniser: asserts asynchronously, releases on the second clock edge.
module reset_sync_2ff (
  input  logic i_clk,
  input  logic i_arst_n,
  output logic o_rst_n
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= 1'b1;
      r_sync <= r_meta;
    end
  end

  assign o_rst_n = r_sync;

endmodule

// File: rtl/reset_sequencer.sv
// Multi-channel reset generator: common assert for a minimum width, then staggered release
// with per-channel hold. State | meaning: ASSERT all held | DELAY soft request pending |
// RELEASE channels dropping in slot order | RUN sequence complete.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_OUT = 4,
  parameter int DELAY   = 10,
  parameter int WIDTH   = 50,
  parameter int STAGGER = 16
) (
  input  logic               clk,
  input  logic               async_reset_n_i,
  input  logic               reset_i,
  input  logic [NUM_OUT-1:0] hold_i,
  output logic [NUM_OUT-1:0] reset_o,
  output logic               done_o
);

  localparam int CNT_W = clog2_f(max3_f(DELAY, WIDTH, STAGGER * (NUM_OUT - 1)) + 1);
  localparam logic [CNT_W-1:0] DLY_TC = (DELAY > 0) ? CNT_W'(DELAY - 1) : '0;
  localparam logic [CNT_W-1:0] WID_TC = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] REL_TC = CNT_W'(STAGGER * (NUM_OUT - 1));

  if (NUM_OUT < 1) begin : g_chk_num_out
    $error("reset_sequencer: NUM_OUT must be >= 1");
  end
  if (WIDTH < 1) begin : g_chk_width
    $error("reset_sequencer: WIDTH must be >= 1");
  end

  logic               w_rst_n;
  seq_state_e         r_state;
  seq_state_e         w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [NUM_OUT-1:0] r_armed;
  logic [NUM_OUT-1:0] w_armed_nxt;
  logic [NUM_OUT-1:0] w_slot;
  logic [NUM_OUT-1:0] r_reset;
  logic [NUM_OUT-1:0] w_reset_nxt;
  logic               r_done;
  logic               w_seq;

  reset_sync_2ff u_sync (
    .i_clk    (clk),
    .i_arst_n (async_reset_n_i),
    .o_rst_n  (w_rst_n)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_RUN: begin
        if (reset_i) begin
          w_state_nxt = (DELAY == 0) ? ST_ASSERT : ST_DELAY;
          w_cnt_nxt   = '0;
        end
      end
      ST_DELAY: begin
        if (r_cnt == DLY_TC) begin
          w_state_nxt = ST_ASSERT;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_ASSERT: begin
        if (reset_i) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == WID_TC) begin
          w_state_nxt = (REL_TC == '0) ? ST_RUN : ST_RELEASE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (reset_i) begin
          w_state_nxt = ST_ASSERT;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
          if (w_cnt_nxt == REL_TC) w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_ASSERT;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Slots are judged on the next-state count so each channel drops on the edge its slot begins.
  assign w_seq = (w_state_nxt == ST_RELEASE) || ((w_state_nxt == ST_RUN) && (r_state != ST_RUN));

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_ch
    localparam logic [CNT_W-1:0] SLOT = CNT_W'(k * STAGGER);
    assign w_slot[k] = w_seq && (w_cnt_nxt == SLOT);
  end

  assign w_armed_nxt = (w_state_nxt == ST_ASSERT) ? '0 : (r_armed | w_slot);
  assign w_reset_nxt = (w_state_nxt == ST_ASSERT) ? '1 : (r_reset & ~(w_armed_nxt & ~hold_i));

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= ST_ASSERT;
      r_cnt   <= '0;
      r_armed <= '0;
      r_reset <= '1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_armed <= w_armed_nxt;
      r_reset <= w_reset_nxt;
      r_done  <= (w_state_nxt == ST_RUN);
    end
  end

  assign reset_o = r_reset;
  assign done_o  = r_done;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: default instance plus two corner-parameter instances.
module tb_reset_sequencer;

  typedef struct {
    int          cyc;
    int          sel;
    logic [7:0]  val;
    string       tag;
  } sb_entry_t;

  logic       clk;
  logic       rst_n;
  logic       req_a, req_b, req_c;
  logic [3:0] hold_a, hold_b;
  logic [0:0] hold_c;
  logic [3:0] rst_a, rst_b;
  logic [0:0] rst_c;
  logic       done_a, done_b, done_c;

  int        cyc = 0;
  int        n_tests = 0;
  int        n_fail = 0;
  sb_entry_t sb[$];

  reset_sequencer #(.NUM_OUT(4), .DELAY(10), .WIDTH(50), .STAGGER(16)) u_dut (
    .clk(clk), .async_reset_n_i(rst_n), .reset_i(req_a), .hold_i(hold_a),
    .reset_o(rst_a), .done_o(done_a)
  );

  reset_sequencer #(.NUM_OUT(4), .DELAY(0), .WIDTH(5), .STAGGER(0)) u_dut_b (
    .clk(clk), .async_reset_n_i(rst_n), .reset_i(req_b), .hold_i(hold_b),
    .reset_o(rst_b), .done_o(done_b)
  );

  reset_sequencer #(.NUM_OUT(1), .DELAY(3), .WIDTH(4), .STAGGER(16)) u_dut_c (
    .clk(clk), .async_reset_n_i(rst_n), .reset_i(req_c), .hold_i(hold_c),
    .reset_o(rst_c), .done_o(done_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] obs(input int sel);
    case (sel)
      0:       return {3'b000, done_a, rst_a};
      1:       return {3'b000, done_b, rst_b};
      default: return {3'b000, done_c, 3'b000, rst_c};
    endcase
  endfunction

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic at(input int c, input int sel, input logic [7:0] v, input string tag);
    sb_entry_t e;
    int i;
    e = '{c, sel, v, tag};
    i = 0;
    while (i < sb.size() && sb[i].cyc <= c) i++;
    sb.insert(i, e);
  endtask

  always @(negedge clk) begin
    sb_entry_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc < cyc) check_val({e.tag, "_missed"}, 8'(cyc), 8'(e.cyc));
      else check_val(e.tag, obs(e.sel), e.val);
    end
  end

  task automatic drain(input int max_cyc);
    int k;
    k = 0;
    while (sb.size() > 0 && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      check_val("sb_drain_timeout", 8'(sb.size()), 8'd0);
      sb.delete();
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic power_up();
    int c;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check_val("por_a", obs(0), 8'h0F);
    check_val("por_b", obs(1), 8'h0F);
    check_val("por_c", obs(2), 8'h01);
    c = cyc;
    rst_n = 1'b1;
    at(c + 51,  0, 8'h0F, "pu_a_hold_end");
    at(c + 52,  0, 8'h0E, "pu_a_ch0");
    at(c + 67,  0, 8'h0E, "pu_a_pre_ch1");
    at(c + 68,  0, 8'h0C, "pu_a_ch1");
    at(c + 84,  0, 8'h08, "pu_a_ch2");
    at(c + 99,  0, 8'h08, "pu_a_pre_done");
    at(c + 100, 0, 8'h10, "pu_a_done");
    at(c + 6,   1, 8'h0F, "pu_b_hold_end");
    at(c + 7,   1, 8'h10, "pu_b_all_rel");
    at(c + 5,   2, 8'h01, "pu_c_hold_end");
    at(c + 6,   2, 8'h10, "pu_c_rel");
    drain(130);
  endtask

  task automatic begin_req_a(output int t);
    @(negedge clk);
    t = cyc;
    req_a = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst_n  = 1'b1;
    req_a  = 1'b0;
    req_b  = 1'b0;
    req_c  = 1'b0;
    hold_a = 4'h0;
    hold_b = 4'h0;
    hold_c = 1'b0;
    #1;

    power_up();

    // soft reset pulse from RUN
    begin_req_a(t);
    at(t + 1,   0, 8'h00, "soft_done_low");
    at(t + 10,  0, 8'h00, "soft_pre_assert");
    at(t + 11,  0, 8'h0F, "soft_assert");
    at(t + 60,  0, 8'h0F, "soft_hold_end");
    at(t + 61,  0, 8'h0E, "soft_ch0");
    at(t + 77,  0, 8'h0C, "soft_ch1");
    at(t + 93,  0, 8'h08, "soft_ch2");
    at(t + 108, 0, 8'h08, "soft_pre_done");
    at(t + 109, 0, 8'h10, "soft_done");
    @(negedge clk);
    req_a = 1'b0;
    drain(150);

    // stretched request
    begin_req_a(t);
    at(t + 11,  0, 8'h0F, "str_assert");
    at(t + 150, 0, 8'h0F, "str_mid");
    at(t + 249, 0, 8'h0F, "str_hold_end");
    at(t + 250, 0, 8'h0E, "str_ch0");
    at(t + 298, 0, 8'h10, "str_done");
    repeat (200) @(negedge clk);
    req_a = 1'b0;
    drain(150);

    // per-channel hold
    hold_a = 4'b0100;
    begin_req_a(t);
    at(t + 93,  0, 8'h0C, "hold_ch2_kept");
    at(t + 109, 0, 8'h14, "hold_done_anyway");
    at(t + 139, 0, 8'h14, "hold_run30");
    @(negedge clk);
    req_a = 1'b0;
    wait_cyc(t + 139);
    hold_a = 4'b0000;
    at(t + 140, 0, 8'h10, "hold_dropped");
    wait_cyc(t + 145);
    hold_a = 4'b0001;
    at(t + 147, 0, 8'h10, "hold_late_no_effect");
    drain(40);
    hold_a = 4'b0000;

    // abort during RELEASE
    begin_req_a(t);
    at(t + 80,  0, 8'h0C, "abort_pre");
    at(t + 81,  0, 8'h0F, "abort_reassert");
    at(t + 130, 0, 8'h0F, "abort_hold_end");
    at(t + 131, 0, 8'h0E, "abort_ch0");
    at(t + 179, 0, 8'h10, "abort_done");
    @(negedge clk);
    req_a = 1'b0;
    wait_cyc(t + 80);
    req_a = 1'b1;
    @(negedge clk);
    req_a = 1'b0;
    drain(150);

    // corner instances: DELAY=0 / STAGGER=0, and NUM_OUT=1 with DELAY=3
    @(negedge clk);
    t = cyc;
    req_b = 1'b1;
    req_c = 1'b1;
    at(t + 1, 1, 8'h0F, "b_delay0_assert");
    at(t + 5, 1, 8'h0F, "b_hold_end");
    at(t + 6, 1, 8'h10, "b_all_rel");
    at(t + 1, 2, 8'h00, "c_done_low");
    at(t + 3, 2, 8'h00, "c_pre_assert");
    at(t + 4, 2, 8'h01, "c_assert");
    at(t + 7, 2, 8'h01, "c_hold_end");
    at(t + 8, 2, 8'h10, "c_rel");
    @(negedge clk);
    req_b = 1'b0;
    req_c = 1'b0;
    drain(30);

    // async reset mid-RELEASE, then full restart
    begin_req_a(t);
    at(t + 61, 0, 8'h0E, "arst_ch0");
    at(t + 69, 0, 8'h0E, "arst_pre");
    @(negedge clk);
    req_a = 1'b0;
    wait_cyc(t + 70);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_immediate_a", obs(0), 8'h0F);
    check_val("arst_immediate_c", obs(2), 8'h01);
    power_up();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
